control_unit: RTL
=================

# control_unit

Multi-cycle control unit for the 64-bit RISC-V datapath (`cpu`). It sits directly upstream of the datapath and holds the program counter. It fetches each instruction over a request/valid handshake and decodes it. It then sequences the datapath control inputs (register-file addresses, immediate, mux selects, ALU operation, write enables) through one state per phase. The outputs connect one-to-one to the `cpu_*` control ports of the datapath.

## Interface
- `WORDSIZE`, 64, datapath width; the immediate and PC are this wide.
- `RESET_PC`, 0, PC value loaded on reset.
- `cu_clk`  in  1  clock; all state changes on the rising edge.
- `cu_rst_n`  in  1  asynchronous, active-low reset.
- `cu_im_valid`  in  1  instruction memory has `cu_im_instr` ready.
- `cu_im_instr`  in  32  fetched instruction.
- `cu_alu_zero`  in  1  datapath ALU result == 0.
- `cu_im_req`  out  1  fetch request.
- `cu_pc`  out  WORDSIZE  current PC, used as the fetch address.
- `cu_rf_addr_a`, `cu_rf_addr_b`, `cu_rf_write_addr`  out  5 each  rs1, rs2, rd.
- `cu_rf_write_en`  out  1  register-file write strobe.
- `cu_immediate`  out  WORDSIZE  sign-extended immediate.
- `cu_mux_0_sel`  out  1  ALU A: 0 = rf_data_a, 1 = PC.
- `cu_mux_1_sel`  out  1  ALU B: 0 = immediate, 1 = rf_data_b.
- `cu_mux_2_sel`  out  1  writeback: 0 = ALU result, 1 = dm_data_output.
- `cu_alu_operation`  out  3  0 add, 1 sub, 2 and, 3 or, 4 xor, 5 sll, 6 srl, 7 slt.
- `cu_dm_write_en`  out  1  data-memory write strobe.
- `cu_illegal`  out  1  sticky illegal-instruction flag.

## Operation
- States: FETCH, DECODE, EXECUTE, MEM, WB, TRAP. State is registered; outputs are a Moore decode of the state and the latched instruction register (IR).
- FETCH:
  - `cu_im_req`=1. On the first edge with `cu_im_valid`=1, load IR with `cu_im_instr` and go to DECODE. Otherwise stay in FETCH.
  - `cu_im_valid` is ignored in every other state.
- DECODE:
  - Drive rs1, rs2 and rd from the IR. Build the I, S or B immediate, sign-extended to WORDSIZE.
  - A legal opcode goes to EXECUTE. Any other opcode goes to TRAP.
- Supported instructions:
  - R-type 0110011: add, sub, and, or, xor, sll, srl, slt.
  - I-type 0010011: addi, andi, ori, xori, slti.
  - lw 0000011, sw 0100011.
  - beq/bne 1100011 (see Configuration).
  - Any funct3/funct7 combination outside these is illegal.
- EXECUTE:
  - R-type: `mux_1_sel`=1 with the decoded ALU op.
  - I-type, lw, sw: `mux_1_sel`=0; ALU op is add for lw/sw.
  - Branch: sub with `mux_1_sel`=1.
  - Next state: lw/sw go to MEM; R/I go to WB; branch goes to FETCH.
- MEM: ALU inputs are held. `cu_dm_write_en`=1 for sw only. sw then goes to FETCH; lw goes to WB.
- WB: `cu_rf_write_en`=1 for exactly one cycle. `mux_2_sel`=1 for lw, 0 otherwise. Then go to FETCH.
- Writes to rd=x0 are suppressed: `cu_rf_write_en` stays 0.
- PC update, taken on the edge that leaves the final state of the instruction:
  - Branch taken (beq with zero=1, or bne with zero=0): PC ← PC + imm.
  - All other instructions: PC ← PC + 4.
  - Arithmetic is modulo 2^WORDSIZE; wrap-around is silent.
- TRAP: `cu_illegal`=1. All strobes and `cu_im_req` are 0. The PC is frozen and the block stays in TRAP until reset.
- Outside their active states, all strobes, selects and the ALU op are 0.

## Timing
- Reset (asynchronous assertion) sets:
  - state = FETCH, PC = RESET_PC, IR = 0.
  - All outputs = 0, including `cu_im_req`. `cu_im_req` is forced to 0 while `cu_rst_n`=0.
- `cu_im_req` rises in the first cycle after reset deassertion.
- Minimum cycle counts, with `cu_im_valid` already high in FETCH:
  - branch: 3.
  - R/I and sw: 4.
  - lw: 5.
  - Each FETCH wait cycle adds 1.
- Strobes last exactly one cycle per instruction.
- The new PC is visible in the cycle the block re-enters FETCH.
- A reset in the middle of an instruction aborts it. No strobe is asserted after `cu_rst_n` falls.

## Configuration
- `CU_BRANCH_EN` defined: beq/bne are decoded as described above.
- `CU_BRANCH_EN` undefined: opcode 1100011 is illegal and goes to TRAP. `cu_alu_zero` is unused.

## Test plan
- Reset, then `cu_im_valid`=1 with lw x2,5(x7): EXECUTE shows addr_a=7, imm=5, mux_1=0, op=0. WB shows write_addr=2, write_en=1, mux_2=1. PC 0→4 after 5 cycles.
- sw x3,-8(x1): imm=0xFFFF_FFFF_FFFF_FFF8. `dm_write_en` is high for one cycle in MEM. `rf_write_en` is never high. PC +4.
- add x5,x6,x7 with `cu_im_valid` delayed 3 cycles: `cu_im_req` is held high for 3 cycles. op=0, mux_1=1, write_en in cycle 7. addi x0,x0,1 gives no write strobe.
- beq with imm=-16 at PC=0x20: zero=1 gives PC 0x10; zero=0 gives PC 0x24. Without `CU_BRANCH_EN`, the same instruction goes to TRAP.
- Instruction 0xFFFFFFFF: `cu_illegal`=1 and the block stays in TRAP with PC frozen for 20 cycles. Reset clears the flag.
- Assert `cu_rst_n`=0 during WB of an add: `rf_write_en` drops immediately, PC=RESET_PC, state=FETCH.

Source files
------------

// File: rtl/control_unit_if.sv
// Fetch handshake and datapath control bundle between control_unit and the cpu datapath.
interface control_unit_if #(
   parameter int WORDSIZE = 64
);
   logic                cu_im_valid;
   logic [31:0]         cu_im_instr;
   logic                cu_alu_zero;
   logic                cu_im_req;
   logic [WORDSIZE-1:0] cu_pc;
   logic [4:0]          cu_rf_addr_a;
   logic [4:0]          cu_rf_addr_b;
   logic [4:0]          cu_rf_write_addr;
   logic                cu_rf_write_en;
   logic [WORDSIZE-1:0] cu_immediate;
   logic                cu_mux_0_sel;
   logic                cu_mux_1_sel;
   logic                cu_mux_2_sel;
   logic [2:0]          cu_alu_operation;
   logic                cu_dm_write_en;
   logic                cu_illegal;

   modport master (
      input  cu_im_valid, cu_im_instr, cu_alu_zero,
      output cu_im_req, cu_pc, cu_rf_addr_a, cu_rf_addr_b, cu_rf_write_addr,
             cu_rf_write_en, cu_immediate, cu_mux_0_sel, cu_mux_1_sel,
             cu_mux_2_sel, cu_alu_operation, cu_dm_write_en, cu_illegal
   );

   modport slave (
      output cu_im_valid, cu_im_instr, cu_alu_zero,
      input  cu_im_req, cu_pc, cu_rf_addr_a, cu_rf_addr_b, cu_rf_write_addr,
             cu_rf_write_en, cu_immediate, cu_mux_0_sel, cu_mux_1_sel,
             cu_mux_2_sel, cu_alu_operation, cu_dm_write_en, cu_illegal
   );
endinterface

// File: rtl/control_unit.sv
// Multi-cycle fetch/decode/sequence control unit for the 64-bit RISC-V datapath.
// Define CU_BRANCH_EN to decode beq/bne; without it opcode 1100011 traps.
module control_unit #(
   parameter int                  WORDSIZE = 64,
   parameter logic [WORDSIZE-1:0] RESET_PC = '0
) (
   input  logic           cu_clk,
   input  logic           cu_rst_n,
   control_unit_if.master bus
);

   typedef enum logic [2:0] {FETCH, DECODE, EXECUTE, MEM, WB, TRAP} state_t;
   typedef enum logic [2:0] {K_R, K_I, K_LOAD, K_STORE, K_BRANCH, K_BAD} kind_t;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   function automatic kind_t classify(input logic [31:0] ins);
      kind_t k;
      k = K_BAD;
      case (ins[6:0])
         OP_R: begin
            if (ins[31:25] == 7'b0000000 && ins[14:12] != 3'b011)
               k = K_R;
            else if (ins[31:25] == 7'b0100000 && ins[14:12] == 3'b000)
               k = K_R;
         end
         OP_I:     if (ins[14:12] inside {3'b000, 3'b010, 3'b100, 3'b110, 3'b111}) k = K_I;
         OP_LOAD:  if (ins[14:12] == 3'b010) k = K_LOAD;
         OP_STORE: if (ins[14:12] == 3'b010) k = K_STORE;
`ifdef CU_BRANCH_EN
         OP_BRANCH: if (ins[14:13] == 2'b00) k = K_BRANCH;
`endif
         default:  k = K_BAD;
      endcase
      return k;
   endfunction

   // R and I share the funct3 map; only R with funct7[5] turns add into sub.
   function automatic logic [2:0] alu_op(input logic [31:0] ins, input kind_t k);
      logic [2:0] op;
      op = 3'd0;
      if (k == K_R || k == K_I) begin
         case (ins[14:12])
            3'b000:  op = (k == K_R && ins[30]) ? 3'd1 : 3'd0;
            3'b111:  op = 3'd2;
            3'b110:  op = 3'd3;
            3'b100:  op = 3'd4;
            3'b001:  op = 3'd5;
            3'b101:  op = 3'd6;
            3'b010:  op = 3'd7;
            default: op = 3'd0;
         endcase
      end else if (k == K_BRANCH) begin
         op = 3'd1;
      end
      return op;
   endfunction

   function automatic logic [WORDSIZE-1:0] imm_of(input logic [31:0] ins, input kind_t k);
      logic [WORDSIZE-1:0] imm;
      case (k)
         K_I, K_LOAD: imm = {{(WORDSIZE-12){ins[31]}}, ins[31:20]};
         K_STORE:     imm = {{(WORDSIZE-12){ins[31]}}, ins[31:25], ins[11:7]};
         K_BRANCH:    imm = {{(WORDSIZE-13){ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
         default:     imm = '0;
      endcase
      return imm;
   endfunction

   state_t              state_reg, state_next;
   logic [31:0]         ir_reg, ir_next;
   logic [WORDSIZE-1:0] pc_reg, pc_next;
   kind_t               kind_cur, kind_next;
   logic                branch_taken;

   logic                im_req_reg, im_req_next;
   logic [4:0]          addr_a_reg, addr_a_next;
   logic [4:0]          addr_b_reg, addr_b_next;
   logic [4:0]          write_addr_reg, write_addr_next;
   logic                rf_we_reg, rf_we_next;
   logic [WORDSIZE-1:0] imm_reg, imm_next;
   logic                mux_1_reg, mux_1_next;
   logic                mux_2_reg, mux_2_next;
   logic [2:0]          alu_op_reg, alu_op_next;
   logic                dm_we_reg, dm_we_next;
   logic                illegal_reg, illegal_next;

`ifdef CU_BRANCH_EN
   // funct3[0] distinguishes bne from beq.
   assign branch_taken = ir_reg[12] ? ~bus.cu_alu_zero : bus.cu_alu_zero;
`else
   logic unused_alu_zero;
   assign unused_alu_zero = bus.cu_alu_zero;
   assign branch_taken    = 1'b0;
`endif

   always_comb begin
      state_next = state_reg;
      ir_next    = ir_reg;
      pc_next    = pc_reg;
      kind_cur   = classify(ir_reg);
      case (state_reg)
         FETCH: begin
            // The handshake completes only once our own request is visible.
            if (im_req_reg && bus.cu_im_valid) begin
               ir_next    = bus.cu_im_instr;
               state_next = DECODE;
            end
         end
         DECODE:  state_next = (kind_cur == K_BAD) ? TRAP : EXECUTE;
         EXECUTE: begin
            case (kind_cur)
               K_LOAD, K_STORE: state_next = MEM;
               K_BRANCH: begin
                  state_next = FETCH;
                  pc_next    = branch_taken ? pc_reg + imm_of(ir_reg, kind_cur)
                                            : pc_reg + WORDSIZE'(4);
               end
               default: state_next = WB;
            endcase
         end
         MEM: begin
            if (kind_cur == K_STORE) begin
               state_next = FETCH;
               pc_next    = pc_reg + WORDSIZE'(4);
            end else begin
               state_next = WB;
            end
         end
         WB: begin
            state_next = FETCH;
            pc_next    = pc_reg + WORDSIZE'(4);
         end
         TRAP:    state_next = TRAP;
         default: state_next = FETCH;
      endcase
   end

   // Outputs are a Moore decode of the upcoming state, registered alongside it.
   always_comb begin
      kind_next       = classify(ir_next);
      im_req_next     = (state_next == FETCH);
      illegal_next    = (state_next == TRAP);
      addr_a_next     = 5'd0;
      addr_b_next     = 5'd0;
      write_addr_next = 5'd0;
      imm_next        = '0;
      rf_we_next      = 1'b0;
      mux_1_next      = 1'b0;
      mux_2_next      = 1'b0;
      alu_op_next     = 3'd0;
      dm_we_next      = 1'b0;
      if (state_next inside {DECODE, EXECUTE, MEM, WB}) begin
         addr_a_next     = ir_next[19:15];
         addr_b_next     = ir_next[24:20];
         write_addr_next = ir_next[11:7];
         imm_next        = imm_of(ir_next, kind_next);
      end
      // ALU inputs stay put through MEM and WB so the result remains valid.
      if (state_next inside {EXECUTE, MEM, WB}) begin
         mux_1_next  = (kind_next == K_R) || (kind_next == K_BRANCH);
         alu_op_next = alu_op(ir_next, kind_next);
      end
      if (state_next == MEM)
         dm_we_next = (kind_next == K_STORE);
      if (state_next == WB) begin
         rf_we_next = (ir_next[11:7] != 5'd0);
         mux_2_next = (kind_next == K_LOAD);
      end
   end

   always_ff @(posedge cu_clk or negedge cu_rst_n) begin
      if (!cu_rst_n) begin
         state_reg      <= FETCH;
         ir_reg         <= '0;
         pc_reg         <= RESET_PC;
         im_req_reg     <= 1'b0;
         addr_a_reg     <= 5'd0;
         addr_b_reg     <= 5'd0;
         write_addr_reg <= 5'd0;
         rf_we_reg      <= 1'b0;
         imm_reg        <= '0;
         mux_1_reg      <= 1'b0;
         mux_2_reg      <= 1'b0;
         alu_op_reg     <= 3'd0;
         dm_we_reg      <= 1'b0;
         illegal_reg    <= 1'b0;
      end else begin
         state_reg      <= state_next;
         ir_reg         <= ir_next;
         pc_reg         <= pc_next;
         im_req_reg     <= im_req_next;
         addr_a_reg     <= addr_a_next;
         addr_b_reg     <= addr_b_next;
         write_addr_reg <= write_addr_next;
         rf_we_reg      <= rf_we_next;
         imm_reg        <= imm_next;
         mux_1_reg      <= mux_1_next;
         mux_2_reg      <= mux_2_next;
         alu_op_reg     <= alu_op_next;
         dm_we_reg      <= dm_we_next;
         illegal_reg    <= illegal_next;
      end
   end

   assign bus.cu_im_req        = im_req_reg;
   assign bus.cu_pc            = pc_reg;
   assign bus.cu_rf_addr_a     = addr_a_reg;
   assign bus.cu_rf_addr_b     = addr_b_reg;
   assign bus.cu_rf_write_addr = write_addr_reg;
   assign bus.cu_rf_write_en   = rf_we_reg;
   assign bus.cu_immediate     = imm_reg;
   // No supported instruction feeds the PC into the ALU.
   assign bus.cu_mux_0_sel     = 1'b0;
   assign bus.cu_mux_1_sel     = mux_1_reg;
   assign bus.cu_mux_2_sel     = mux_2_reg;
   assign bus.cu_alu_operation = alu_op_reg;
   assign bus.cu_dm_write_en   = dm_we_reg;
   assign bus.cu_illegal       = illegal_reg;

endmodule
